sid_bus_master: RTL



---
 rtl/sid_bus_master.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/sid_bus_master.sv
// SID bus initiator: queues timed register commands in a FIFO and replays them
// onto the SID write-enable/address/data pins aligned to the 1 MHz enable.
module sid_bus_master #(
    parameter int FIFO_DEPTH = 16,
    parameter int DELAY_W    = 16
) (
    input  logic                          clk,
    input  logic                          iRstN,
    input  logic                          iClkEn,
    input  logic                          iCmdValid,
    output logic                          oCmdReady,
    input  logic                          iCmdRead,
    input  logic [4:0]                    iCmdAddr,
    input  logic [7:0]                    iCmdData,
    input  logic [DELAY_W-1:0]            iCmdDelay,
    output logic                          oRespValid,
    input  logic                          iRespReady,
    output logic [7:0]                    oRespData,
    output logic                          oWE,
    output logic [4:0]                    oAddr,
    output logic [7:0]                    oDataW,
    input  logic [7:0]                    iDataR,
    output logic [$clog2(FIFO_DEPTH):0]   oLevel,
    output logic                          oBusy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 1 + 5 + 8 + DELAY_W;

    localparam logic [AW-1:0]      PTR_ONE  = AW'(1);
    localparam logic [LW-1:0]      LVL_ONE  = LW'(1);
    localparam logic [LW-1:0]      LVL_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0]      LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [DELAY_W-1:0] CNT_ONE  = DELAY_W'(1);
    localparam logic [DELAY_W-1:0] CNT_ZERO = {DELAY_W{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_READ  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    logic [EW-1:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    state_t             state_q, state_d;
    logic               w_read_q, w_read_d;
    logic [4:0]         w_addr_q, w_addr_d;
    logic [7:0]         w_data_q, w_data_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [4:0]         addr_q, addr_d;
    logic [7:0]         dataw_q, dataw_d;
    logic               rv_q, rv_d;
    logic [7:0]         rdata_q, rdata_d;

    logic               push_s, pop_s, full_s;
    logic [EW-1:0]      head_s;

    assign full_s    = (level_q == LVL_FULL);
    assign oCmdReady = ~full_s;
    assign push_s    = iCmdValid & ~full_s;
    assign head_s    = mem_q[rd_ptr_q];
    assign wr_ptr_d  = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    assign rd_ptr_d  = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    // FIFO storage: data only, validity is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {iCmdRead, iCmdAddr, iCmdData, iCmdDelay};
        end
    end

    // Occupancy: simultaneous push and pop leaves the level unchanged.
    always_comb begin
        level_d = level_q;
        if (push_s && !pop_s) begin
            level_d = level_q + LVL_ONE;
        end else if (!push_s && pop_s) begin
            level_d = level_q - LVL_ONE;
        end else begin
            level_d = level_q;
        end
    end

    // Command sequencer next state and registered bus outputs.
    always_comb begin
        state_d  = state_q;
        pop_s    = 1'b0;
        w_read_d = w_read_q;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        cnt_d    = cnt_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        dataw_d  = dataw_q;
        rv_d     = rv_q;
        rdata_d  = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (level_q != LVL_ZERO) begin
                    pop_s    = 1'b1;
                    w_read_d = head_s[EW-1];
                    w_addr_d = head_s[EW-2 -: 5];
                    w_data_d = head_s[DELAY_W+7 -: 8];
                    cnt_d    = head_s[DELAY_W-1:0];
                    state_d  = ST_WAIT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (iClkEn) begin
                    if (cnt_q == CNT_ZERO) begin
                        state_d = ST_ISSUE;
                        addr_d  = w_addr_q;
                        dataw_d = w_data_q;
                        we_d    = ~w_read_q;
                    end else begin
                        cnt_d   = cnt_q - CNT_ONE;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ISSUE: begin
                if (w_read_q) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                // iDataR is combinational from oAddr, which is stable this cycle.
                rdata_d = iDataR;
                rv_d    = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (iRespReady) begin
                    rv_d    = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state and output registers.
    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= LVL_ZERO;
            state_q  <= ST_IDLE;
            w_read_q <= 1'b0;
            w_addr_q <= 5'd0;
            w_data_q <= 8'd0;
            cnt_q    <= CNT_ZERO;
            we_q     <= 1'b0;
            addr_q   <= 5'd0;
            dataw_q  <= 8'd0;
            rv_q     <= 1'b0;
            rdata_q  <= 8'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            w_read_q <= w_read_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            dataw_q  <= dataw_d;
            rv_q     <= rv_d;
            rdata_q  <= rdata_d;
        end
    end

    assign oWE        = we_q;
    assign oAddr      = addr_q;
    assign oDataW     = dataw_q;
    assign oRespValid = rv_q;
    assign oRespData  = rdata_q;
    assign oLevel     = level_q;
    assign oBusy      = (level_q != LVL_ZERO) | (state_q != ST_IDLE);

endmodule
